// File: rtl/vga_pkg.sv
// Shared VGA timing constants, default image geometry and small helpers
// used by the pixel fetch block and the timing generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    localparam int IMG_W_DEF  = 256;
    localparam int IMG_H_DEF  = 256;
    localparam int X_RAW_DEF  = 32;
    localparam int X_FLT_DEF  = 352;
    localparam int Y_TOP_DEF  = 112;
    localparam int RD_LAT_DEF = 2;

    // Idle value of the {hsync, vsync, frame_start} delay line.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    // Per-pixel decode result carried alongside the memory read.
    typedef struct packed {
        logic raw_hit;
        logic flt_hit;
        logic border;
        logic video_on;
    } pix_flags_t;

    // True when lo <= v < lo + n.
    function automatic logic in_span(input int v, input int lo, input int n);
        return (v >= lo) && (v < lo + n);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Parameterised-width, parameterised-depth shift register with an
// asynchronous reset value; used for the sync, flag and frame_start lines.
module sig_delay #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [W-1:0]  i_d,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per clock; every stage returns to RST_VAL on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches raw and filtered image pixels for two on-screen windows, turns
// them into grey VGA colour with a white one-pixel frame, and delays the
// syncs so that colour and sync leave the block aligned.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int X_RAW  = X_RAW_DEF,
    parameter int X_FLT  = X_FLT_DEF,
    parameter int Y_TOP  = Y_TOP_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        mode,
    output logic [15:0] raw_addr,
    output logic        raw_rd,
    input  logic [7:0]  raw_data,
    output logic [15:0] flt_addr,
    output logic        flt_rd,
    input  logic [7:0]  flt_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    logic       w_in_y, w_ring_y;
    logic       w_raw_x, w_raw_ring_x, w_flt_x, w_flt_ring_x;
    logic       w_raw_hit, w_flt_hit, w_border, w_frame_start;
    logic [7:0] w_dy, w_dx_raw, w_dx_flt;
    logic       w_unused_low;

    logic        r_mode;
    logic        r_raw_rd, r_flt_rd, r_border, r_video_on;
    logic [15:0] r_raw_addr, r_flt_addr;
    logic [2:0]  r_sync;
    logic [2:0]  w_sync_d;
    pix_flags_t  w_flags_s0, w_flags_d;
    logic [3:0]  w_grey, r_grey;

    // Window and border decode on the incoming position. The border ring is
    // the window grown by one pixel on each side, minus the window itself.
    assign w_in_y       = in_span(int'(y), Y_TOP, IMG_H);
    assign w_ring_y     = in_span(int'(y), Y_TOP - 1, IMG_H + 2);
    assign w_raw_x      = in_span(int'(x), X_RAW, IMG_W);
    assign w_raw_ring_x = in_span(int'(x), X_RAW - 1, IMG_W + 2);
    assign w_flt_x      = in_span(int'(x), X_FLT, IMG_W);
    assign w_flt_ring_x = in_span(int'(x), X_FLT - 1, IMG_W + 2);

    // The raw window is only shown in side-by-side mode.
    assign w_raw_hit = video_on && !r_mode && w_in_y && w_raw_x;
    assign w_flt_hit = video_on && w_in_y && w_flt_x;
    assign w_border  = video_on &&
                       ((!r_mode && w_ring_y && w_raw_ring_x && !(w_in_y && w_raw_x)) ||
                        (w_ring_y && w_flt_ring_x && !(w_in_y && w_flt_x)));

    assign w_frame_start = (x == 10'd0) && (y == 10'd0);

    // Images are 256 wide, so the address is just {row, column}; only the
    // low 8 bits of each offset matter.
    assign w_dy     = y[7:0] - 8'(Y_TOP);
    assign w_dx_raw = x[7:0] - 8'(X_RAW);
    assign w_dx_flt = x[7:0] - 8'(X_FLT);

    // Only the top nibble of each pixel becomes colour.
    assign w_unused_low = ^{raw_data[3:0], flt_data[3:0]};

    // S0: issue reads, hold addresses between hits, latch mode once per frame
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_raw_rd   <= 1'b0;
            r_flt_rd   <= 1'b0;
            r_raw_addr <= '0;
            r_flt_addr <= '0;
            r_border   <= 1'b0;
            r_video_on <= 1'b0;
            r_sync     <= SYNC_IDLE;
        end else begin
            if (w_frame_start) begin
                r_mode <= mode;
            end
            r_raw_rd <= w_raw_hit;
            r_flt_rd <= w_flt_hit;
            if (w_raw_hit) begin
                r_raw_addr <= {w_dy, w_dx_raw};
            end
            if (w_flt_hit) begin
                r_flt_addr <= {w_dy, w_dx_flt};
            end
            r_border   <= w_border;
            r_video_on <= video_on;
            r_sync     <= {hsync_in, vsync_in, w_frame_start};
        end
    end

    assign raw_rd   = r_raw_rd;
    assign flt_rd   = r_flt_rd;
    assign raw_addr = r_raw_addr;
    assign flt_addr = r_flt_addr;

    assign w_flags_s0 = '{raw_hit: r_raw_rd, flt_hit: r_flt_rd,
                          border: r_border, video_on: r_video_on};

    // Flags wait for the memory; they arrive together with the read data.
    sig_delay #(
        .W       ($bits(pix_flags_t)),
        .DEPTH   (RD_LAT),
        .RST_VAL ('0)
    ) u_flag_delay (
        .i_clk (clk25),
        .i_rst (rst),
        .i_d   (w_flags_s0),
        .o_q   (w_flags_d)
    );

    // Syncs get one extra stage to match the colour output register.
    sig_delay #(
        .W       (3),
        .DEPTH   (RD_LAT + 1),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .i_clk (clk25),
        .i_rst (rst),
        .i_d   (r_sync),
        .o_q   (w_sync_d)
    );

    assign hsync       = w_sync_d[2];
    assign vsync       = w_sync_d[1];
    assign frame_start = w_sync_d[0];

    // Choose the grey level for the pixel whose read was issued RD_LAT ago
    always_comb begin
        w_grey = 4'h0;
        if (w_flags_d.video_on) begin
            if (w_flags_d.raw_hit) begin
                w_grey = raw_data[7:4];
            end else if (w_flags_d.flt_hit) begin
                w_grey = flt_data[7:4];
            end else if (w_flags_d.border) begin
                w_grey = 4'hF;
            end
        end
    end

    // Output colour register
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_grey <= 4'h0;
        end else begin
            r_grey <= w_grey;
        end
    end

    assign vga_r = r_grey;
    assign vga_g = r_grey;
    assign vga_b = r_grey;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: drives compressed frames (selected full lines),
// models both image memories, and scoreboards colour/sync and read ports.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    logic        clk25 = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        video_on, hsync_in, vsync_in, mode;
    logic [15:0] raw_addr, flt_addr;
    logic        raw_rd, flt_rd;
    logic [7:0]  raw_data, flt_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } pix_t;

    typedef struct packed {
        logic        rrd;
        logic [15:0] ra;
        logic        frd;
        logic [15:0] fa;
    } rd_t;

    typedef struct { int xi; int yi; pix_t p; } pix_exp_t;
    typedef struct { int xi; int yi; rd_t  r; } rd_exp_t;

    localparam pix_t RST_PIX = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    localparam rd_t  RST_RD  = '0;

    pix_exp_t q_pix[$];
    rd_exp_t  q_rd[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   fs_cnt = 0;
    bit   frame_mode = 1'b0;
    bit   mode_drv = 1'b0;
    bit   pending_release = 1'b0;
    logic [15:0] last_ra = '0, last_fa = '0;
    logic [15:0] mem_ra = '0, mem_fa = '0;
    logic        mem_rrd = 1'b0, mem_frd = 1'b0;

    int lines[11] = '{0, 111, 112, 113, 150, 200, 367, 368, 479, 490, 524};

    vga_pixel_fetch dut (
        .clk25       (clk25),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode        (mode),
        .raw_addr    (raw_addr),
        .raw_rd      (raw_rd),
        .raw_data    (raw_data),
        .flt_addr    (flt_addr),
        .flt_rd      (flt_rd),
        .flt_data    (flt_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk25 = ~clk25;

    function automatic logic [7:0] raw_mem(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] flt_mem(input logic [15:0] a);
        return a[15:8] - a[7:0] + 8'h69;
    endfunction

    // Two-cycle read memories; data is junk unless a read was issued.
    always @(posedge clk25) begin
        mem_ra   <= raw_addr;
        mem_rrd  <= raw_rd;
        mem_fa   <= flt_addr;
        mem_frd  <= flt_rd;
        raw_data <= mem_rrd ? raw_mem(mem_ra) : 8'h3C;
        flt_data <= mem_frd ? flt_mem(mem_fa) : 8'hC3;
    end

    task automatic check_reset(input string tag);
        pix_t got_p;
        rd_t  got_r;
        got_p = {vga_r, vga_g, vga_b, hsync, vsync, frame_start};
        got_r = {raw_rd, raw_addr, flt_rd, flt_addr};
        n_vec++;
        assert (got_p === RST_PIX) else begin
            n_err++;
            $error("FAIL %s_pix: observed %h, expected %h", tag, got_p, RST_PIX);
        end
        n_vec++;
        assert (got_r === RST_RD) else begin
            n_err++;
            $error("FAIL %s_rd: observed %h, expected %h", tag, got_r, RST_RD);
        end
    endtask

    // One pixel clock: compare what is due, then drive and predict the next pixel.
    task automatic step(input int xi, input int yi);
        pix_exp_t ep;
        rd_exp_t  er;
        pix_t     got_p;
        rd_t      got_r;
        bit       vo, iny, ry, rh, fh;
        logic [15:0] a_r, a_f;
        logic [7:0]  d;
        @(negedge clk25);
        if (pending_release) begin
            rst = 1'b0;
            pending_release = 1'b0;
            q_pix.delete();
            q_rd.delete();
            repeat (4) q_pix.push_back('{xi: -1, yi: -1, p: RST_PIX});
            q_rd.push_back('{xi: -1, yi: -1, r: RST_RD});
            frame_mode = 1'b0;
            last_ra = '0;
            last_fa = '0;
        end
        got_p = {vga_r, vga_g, vga_b, hsync, vsync, frame_start};
        got_r = {raw_rd, raw_addr, flt_rd, flt_addr};
        if (got_p.fs) fs_cnt++;
        if (q_pix.size() > 0) begin
            ep = q_pix.pop_front();
            n_vec++;
            assert (got_p === ep.p) else begin
                n_err++;
                $error("FAIL pix(x=%0d,y=%0d): observed rgb=%h%h%h hs=%b vs=%b fs=%b, expected rgb=%h%h%h hs=%b vs=%b fs=%b",
                       ep.xi, ep.yi, got_p.r, got_p.g, got_p.b, got_p.hs, got_p.vs, got_p.fs,
                       ep.p.r, ep.p.g, ep.p.b, ep.p.hs, ep.p.vs, ep.p.fs);
            end
        end
        if (q_rd.size() > 0) begin
            er = q_rd.pop_front();
            n_vec++;
            assert (got_r === er.r) else begin
                n_err++;
                $error("FAIL rd(x=%0d,y=%0d): observed raw_rd=%b raw_addr=%h flt_rd=%b flt_addr=%h, expected raw_rd=%b raw_addr=%h flt_rd=%b flt_addr=%h",
                       er.xi, er.yi, got_r.rrd, got_r.ra, got_r.frd, got_r.fa,
                       er.r.rrd, er.r.ra, er.r.frd, er.r.fa);
            end
        end

        vo       = (xi < H_ACTIVE) && (yi < V_ACTIVE);
        x        = 10'(xi);
        y        = 10'(yi);
        video_on = vo;
        hsync_in = !(xi >= 656 && xi < 752);
        vsync_in = !(yi == 490 || yi == 491);
        mode     = mode_drv;
        if (xi == 0 && yi == 0) frame_mode = mode_drv;

        iny = (yi >= 112) && (yi < 368);
        ry  = (yi >= 111) && (yi <= 368);
        rh  = vo && !frame_mode && iny && (xi >= 32) && (xi < 288);
        fh  = vo && iny && (xi >= 352) && (xi < 608);
        a_r = {8'(yi - 112), 8'(xi - 32)};
        a_f = {8'(yi - 112), 8'(xi - 352)};
        if (rh) last_ra = a_r;
        if (fh) last_fa = a_f;
        er.xi = xi;
        er.yi = yi;
        er.r  = {rh, last_ra, fh, last_fa};
        q_rd.push_back(er);

        ep.xi   = xi;
        ep.yi   = yi;
        ep.p.hs = hsync_in;
        ep.p.vs = vsync_in;
        ep.p.fs = (xi == 0) && (yi == 0);
        ep.p.r  = 4'h0;
        if (vo) begin
            if (rh) begin
                d = raw_mem(a_r);
                ep.p.r = d[7:4];
            end else if (fh) begin
                d = flt_mem(a_f);
                ep.p.r = d[7:4];
            end else if ((!frame_mode && ry && xi >= 31 && xi <= 288) ||
                         (ry && xi >= 351 && xi <= 608)) begin
                ep.p.r = 4'hF;
            end
        end
        ep.p.g = ep.p.r;
        ep.p.b = ep.p.r;
        q_pix.push_back(ep);
    endtask

    task automatic run_line(input int yi, input int xs, input int xe);
        for (int xi = xs; xi <= xe; xi++) step(xi, yi);
    endtask

    task automatic mid_reset();
        @(posedge clk25);
        #2 rst = 1'b1;
        #1 check_reset("mid_reset_immediate");
        repeat (2) @(negedge clk25);
        check_reset("mid_reset_hold");
        pending_release = 1'b1;
    endtask

    task automatic run_frame(input bit m0, input bit m200, input bit rst150);
        mode_drv = m0;
        fs_cnt = 0;
        foreach (lines[i]) begin
            if (lines[i] == 200) mode_drv = m200;
            if (rst150 && lines[i] == 150) begin
                run_line(150, 0, 100);
                mid_reset();
                run_line(150, 101, H_TOTAL - 1);
            end else begin
                run_line(lines[i], 0, H_TOTAL - 1);
            end
        end
        n_vec++;
        assert (fs_cnt === 1) else begin
            n_err++;
            $error("FAIL frame_start_count: observed %0d pulses, expected 1", fs_cnt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        x        = '0;
        y        = '0;
        video_on = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        mode     = 1'b0;
        repeat (5) begin
            @(negedge clk25);
            check_reset("reset");
        end
        pending_release = 1'b1;

        run_frame(1'b0, 1'b1, 1'b0);   // side-by-side, mode flips mid-frame
        run_frame(1'b1, 1'b1, 1'b0);   // filtered only
        run_frame(1'b1, 1'b1, 1'b1);   // reset mid-frame clears mode back to 0
        run_frame(1'b0, 1'b0, 1'b0);   // back to side-by-side
        repeat (5) step(H_TOTAL - 1, V_TOTAL - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
